// File: rtl/branch_table_ram.sv
// Multi-way branch predictor table: WAYS parallel block-RAM ways, per-way write mask,
// hardware init sweep after reset/flush, and a registered-compare collision bypass.

module branch_table_way #(
   parameter int DW    = 20,
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;

   // Plain read-before-write template so synthesis infers a simple dual-port RAM;
   // write-first behaviour is layered on top by the parent's bypass mux.
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

module branch_table_ram #(
   parameter int                    DATA_WIDTH  = 20,
   parameter int                    DEPTH       = 512,
   parameter int                    WAYS        = 2,
   parameter int                    WRITE_FIRST = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   output logic                             init_done,
   input  logic [$clog2(DEPTH)-1:0]         read_addr,
   input  logic                             read_en,
   output logic [WAYS*DATA_WIDTH-1:0]       read_data,
   output logic                             read_valid,
   input  logic [$clog2(DEPTH)-1:0]         write_addr,
   input  logic                             write_en,
   input  logic [WAYS-1:0]                  write_way,
   input  logic [WAYS*DATA_WIDTH-1:0]       write_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_READY} state_e;

   state_e                        state_q, state_d;
   logic [AW-1:0]                 cnt_q, cnt_d;
   logic                          rvalid_q;
   logic                          seen_q;
   logic [WAYS-1:0]               byp_q, byp_d;
   logic [WAYS*DATA_WIDTH-1:0]    byp_data_q;

   logic sweeping, rd_acc, wr_acc, collide;

   assign sweeping = (state_q == ST_INIT) && !flush;
   assign rd_acc   = (state_q == ST_READY) && read_en && !flush;
   assign wr_acc   = (state_q == ST_READY) && write_en && !flush;
   assign collide  = wr_acc && (read_addr == write_addr);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = ST_INIT;
         cnt_d   = '0;
      end else if (state_q == ST_INIT) begin
         // Terminal compare, not counter wrap, is what releases the table.
         if (cnt_q == LAST_IDX) state_d = ST_READY;
         cnt_d = cnt_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         rvalid_q   <= 1'b0;
         seen_q     <= 1'b0;
         byp_q      <= '0;
         byp_data_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rd_acc;
         if (rd_acc) begin
            seen_q     <= 1'b1;
            byp_q      <= byp_d;
            byp_data_q <= write_data;
         end
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic                  way_we;
      logic [AW-1:0]         way_waddr;
      logic [DATA_WIDTH-1:0] way_wdata;
      logic [DATA_WIDTH-1:0] way_rdata;

      assign byp_d[w]  = (WRITE_FIRST != 0) && collide && write_way[w];
      assign way_we    = sweeping || (wr_acc && write_way[w]);
      assign way_waddr = sweeping ? cnt_q : write_addr;
      assign way_wdata = sweeping ? INIT_VALUE : write_data[w*DATA_WIDTH +: DATA_WIDTH];

      branch_table_way #(
         .DW    (DATA_WIDTH),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_way (
         .clk     (clk),
         .we_i    (way_we),
         .waddr_i (way_waddr),
         .wdata_i (way_wdata),
         .re_i    (rd_acc),
         .raddr_i (read_addr),
         .rdata_o (way_rdata)
      );

      // seen_q masks the unreset RAM output register until the first real read.
      assign read_data[w*DATA_WIDTH +: DATA_WIDTH] =
         !seen_q   ? '0 :
         byp_q[w]  ? byp_data_q[w*DATA_WIDTH +: DATA_WIDTH] : way_rdata;
   end

   assign init_done  = (state_q == ST_READY);
   assign read_valid = rvalid_q;

endmodule

// File: tb/tb_branch_table_ram.sv
// Randomised scoreboard bench for branch_table_ram; a write-first and a read-first
// instance share stimulus and are checked against one behavioural table model.

module tb_branch_table_ram;
   localparam int D  = 20;
   localparam int N  = 512;
   localparam int W  = 2;
   localparam int AW = 9;
   localparam int BW = W * D;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic flush = 1'b0;
   logic [AW-1:0] read_addr = '0, write_addr = '0;
   logic read_en = 1'b0, write_en = 1'b0;
   logic [W-1:0] write_way = '0;
   logic [BW-1:0] write_data = '0;

   logic init_done_wf, init_done_rf, rvalid_wf, rvalid_rf;
   logic [BW-1:0] rdata_wf, rdata_rf;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   branch_table_ram #(.DATA_WIDTH(D), .DEPTH(N), .WAYS(W), .WRITE_FIRST(1)) u_wf (
      .clk(clk), .rst_n(rst_n), .flush(flush), .init_done(init_done_wf),
      .read_addr(read_addr), .read_en(read_en), .read_data(rdata_wf), .read_valid(rvalid_wf),
      .write_addr(write_addr), .write_en(write_en), .write_way(write_way), .write_data(write_data));

   branch_table_ram #(.DATA_WIDTH(D), .DEPTH(N), .WAYS(W), .WRITE_FIRST(0)) u_rf (
      .clk(clk), .rst_n(rst_n), .flush(flush), .init_done(init_done_rf),
      .read_addr(read_addr), .read_en(read_en), .read_data(rdata_rf), .read_valid(rvalid_rf),
      .write_addr(write_addr), .write_en(write_en), .write_way(write_way), .write_data(write_data));

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: table contents, readiness by edge counting, expected read queue.
   typedef struct { logic [BW-1:0] wf; logic [BW-1:0] rf; } exp_t;
   logic [D-1:0] mem [W][N];
   bit   m_ready = 1'b0;
   int   m_sweep = 0;
   bit   m_pend  = 1'b0;
   exp_t q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready = 1'b0; m_sweep = 0; m_pend = 1'b0; q.delete();
      end else if (flush) begin
         m_ready = 1'b0; m_sweep = 0; m_pend = 1'b0;
      end else if (!m_ready) begin
         for (int w = 0; w < W; w++) mem[w][m_sweep] = '0;
         if (m_sweep == N - 1) m_ready = 1'b1;
         else m_sweep++;
         m_pend = 1'b0;
      end else begin
         m_pend = read_en;
         if (read_en) begin
            exp_t e;
            for (int w = 0; w < W; w++) begin
               logic [D-1:0] old;
               old = mem[w][read_addr];
               e.rf[w*D +: D] = old;
               e.wf[w*D +: D] = (write_en && write_way[w] && write_addr == read_addr)
                                ? write_data[w*D +: D] : old;
            end
            q.push_back(e);
         end
         if (write_en)
            for (int w = 0; w < W; w++)
               if (write_way[w]) mem[w][write_addr] = write_data[w*D +: D];
      end
   end

   // Monitor: compares outputs against the model away from the active edge.
   logic [BW-1:0] last_wf = '0, last_rf = '0;
   always @(negedge clk) begin
      if (chk_en) begin
         if (!rst_n) begin last_wf = '0; last_rf = '0; end
         chk("init_done_wf", BW'(init_done_wf), BW'(m_ready));
         chk("init_done_rf", BW'(init_done_rf), BW'(m_ready));
         chk("read_valid_wf", BW'(rvalid_wf), BW'(m_pend));
         chk("read_valid_rf", BW'(rvalid_rf), BW'(m_pend));
         if (m_pend) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("read_data_wf", rdata_wf, e.wf);
               chk("read_data_rf", rdata_rf, e.rf);
               last_wf = e.wf; last_rf = e.rf;
            end
         end else begin
            chk("hold_wf", rdata_wf, last_wf);
            chk("hold_rf", rdata_rf, last_rf);
         end
      end
   end

   task automatic cyc(input bit re, input logic [AW-1:0] ra, input bit we,
                      input logic [AW-1:0] wa, input logic [W-1:0] ww,
                      input logic [BW-1:0] wd, input bit fl);
      read_en = re; read_addr = ra; write_en = we; write_addr = wa;
      write_way = ww; write_data = wd; flush = fl;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, '0, '0, 0);
   endtask

   // Counts edges until init_done, bounded; the count must be exactly N.
   task automatic sweep_len(input string name);
      int n;
      n = 0;
      while (!init_done_wf && n < N + 50) begin
         cyc(1, 9'd5, 0, '0, '0, '0, 0);
         n++;
      end
      chk(name, BW'(n), BW'(N));
   endtask

   initial begin
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Sweep with a read held on addr 5 throughout.
      sweep_len("sweep_after_reset");
      cyc(1, 9'd5, 0, '0, '0, '0, 0);
      chk("init_read_zero", rdata_wf, '0);

      // Full write then read.
      cyc(0, '0, 1, 9'h1A, 2'b11, {20'h0ABCD, 20'h12345}, 0);
      cyc(1, 9'h1A, 0, '0, '0, '0, 0);
      chk("wr_rd_1A", rdata_wf, {20'h0ABCD, 20'h12345});

      // Partial-mask collision on addr 7.
      cyc(0, '0, 1, 9'd7, 2'b11, {20'h1, 20'h2}, 0);
      cyc(1, 9'd7, 1, 9'd7, 2'b01, {20'hF, 20'hE}, 0);
      chk("collide_wf", rdata_wf, {20'h1, 20'hE});
      chk("collide_rf", rdata_rf, {20'h1, 20'h2});
      cyc(1, 9'd7, 0, '0, '0, '0, 0);
      chk("after_collide_wf", rdata_wf, {20'h1, 20'hE});
      chk("after_collide_rf", rdata_rf, {20'h1, 20'hE});

      // Hold behaviour with read_en low.
      cyc(0, '0, 1, 9'd9, 2'b11, {20'h3, 20'h4}, 0);
      cyc(1, 9'd9, 0, '0, '0, '0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, '0, 0, '0, '0, '0, 0);
         chk("hold_34", rdata_wf, {20'h3, 20'h4});
         chk("hold_valid", BW'(rvalid_wf), '0);
      end

      // Flush with a simultaneous write: the write is dropped.
      cyc(0, '0, 1, 9'd3, 2'b11, {20'h55, 20'h55}, 1);
      chk("flush_drop_done", BW'(init_done_wf), '0);
      sweep_len("sweep_after_flush");
      cyc(1, 9'd3, 0, '0, '0, '0, 0);
      chk("flush_write_dropped", rdata_wf, '0);

      // Reset mid-sweep at count 200, then flush mid-sweep at count 100.
      cyc(0, '0, 0, '0, '0, '0, 1);
      idle(200);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_clears_data", rdata_wf, '0);
      rst_n = 1'b1;
      sweep_len("sweep_after_midreset");
      cyc(0, '0, 0, '0, '0, '0, 1);
      idle(100);
      cyc(0, '0, 0, '0, '0, '0, 1);
      sweep_len("sweep_after_midflush");

      // Randomised traffic, small address window to force collisions.
      for (int i = 0; i < 4000; i++) begin
         logic [AW-1:0] ra, wa;
         ra = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 7));
         wa = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 7));
         cyc(bit'($urandom_range(0, 1)), ra, bit'($urandom_range(0, 1)), wa,
             W'($urandom()), {8'($urandom()), 32'($urandom())},
             $urandom_range(0, 999) == 0);
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_table_ram.md
Name: branch_table_ram

Overview:
Parametrised multi-way successor to the single-port-pair branch predictor RAM.
- Stores WAYS parallel entries per index and returns all ways on a read.
- Provides per-way write enables and a selectable write-first bypass for same-cycle read/write collisions.
- Clears its own contents with a hardware sweep after reset or on flush, so the fetch-side predictor never relies on bitstream initialisation.

Parameters:
DATA_WIDTH, 20, width of one way's entry (tag + target + counter fields packed by the user).
DEPTH, 512, entries per way; power of two, >= 2.
WAYS, 2, number of parallel ways, >= 1.
WRITE_FIRST, 1, 1 = colliding read returns new write data; 0 = colliding read returns old contents.
INIT_VALUE, 0, value (DATA_WIDTH bits) written to every entry during the init sweep.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous request to re-clear the whole table.
init_done  out  1  high when the table is in READY and accepts reads/writes.
read_addr  in  $clog2(DEPTH)  read index.
read_en  in  1  read request.
read_data  out  WAYS*DATA_WIDTH  way i in bits [i*DATA_WIDTH +: DATA_WIDTH].
read_valid  out  1  read_data updated by a read accepted on the previous edge.
write_addr  in  $clog2(DEPTH)  write index.
write_en  in  1  write request.
write_way  in  WAYS  per-way write mask, qualified by write_en.
write_data  in  WAYS*DATA_WIDTH  per-way write data, same packing as read_data.

Behaviour:
- Reset (rst_n low, async):
  - State goes to INIT, sweep counter = 0.
  - init_done = 0, read_valid = 0, read_data = 0.
  - Array contents are not reset directly; the sweep clears them.
- INIT state:
  - Each edge writes INIT_VALUE to all ways at the sweep counter, then increments the counter.
  - The edge that writes index DEPTH-1 sets init_done = 1 and enters READY. Sweep therefore takes exactly DEPTH edges after rst_n rises.
  - External read_en and write_en are ignored. read_valid stays 0 and read_data holds its value.
- READY state:
  - Write: for each way i with write_en & write_way[i], mem[i][write_addr] <= write_data slice i.
  - Read: if read_en, every way's read_data <= mem[read_addr] with 1-cycle latency, and read_valid <= 1.
  - If read_en = 0: read_valid <= 0 and read_data holds its last value.
- Collision (read_en & write_en & read_addr == write_addr, same edge):
  - WRITE_FIRST = 1: each way with write_way set returns the new write_data; ways without it return stored data.
  - WRITE_FIRST = 0: all ways return pre-write contents.
  - The write always completes.
- Flush:
  - flush high on any edge (READY or INIT) sets state to INIT, sweep counter = 0, init_done = 0, read_valid = 0.
  - Any write or read presented on that edge is dropped.
  - Flush during INIT restarts the sweep from 0.
  - Flush held high keeps the block in INIT at counter 0.
- Reset asserted mid-sweep or mid-operation takes effect immediately. The sweep restarts fully after release.
- Address arithmetic: sweep counter is $clog2(DEPTH) bits plus terminal detect at DEPTH-1. No wrap into READY without the terminal compare.
- The array must map to block RAM: one write port and one read port per way.
  - The collision bypass is implemented with a registered address compare plus output mux, not a RAM read-first/write-first attribute.

Test Plan:
(Defaults; WAYS=2; INIT_VALUE=0.)
1. Release rst_n, then drive read_en=1 at addr 5 throughout -> init_done rises exactly 512 edges after release; read_valid stays 0 until one edge after the first READY read; read_data = 0 on both ways.
2. READY: write addr 0x1A, write_way=2'b11, data {0x0ABCD, 0x12345}; next cycle read 0x1A -> one cycle later read_data = {0x0ABCD, 0x12345}, read_valid=1.
3. Collision with WRITE_FIRST=1: table addr 7 holds {0x1, 0x2}. Same edge: write addr 7, write_way=2'b01, data {0xF, 0xE}, and read addr 7 -> read_data = {0x1, 0xE}. A subsequent read returns {0x1, 0xE}. Repeat with WRITE_FIRST=0 -> first read returns {0x1, 0x2}.
4. Flush in READY with a simultaneous write to addr 3 = 0x55 -> init_done falls next edge and rises 512 edges later; read addr 3 returns 0, so the write was dropped.
5. Assert rst_n low at sweep count 200 for 3 cycles, then release -> init_done rises exactly 512 edges after the release. Also pulse flush at sweep count 100 -> the 512-edge count restarts from the pulse.
6. read_en low for 4 cycles after a valid read of {0x3, 0x4} -> read_data holds {0x3, 0x4} and read_valid = 0 throughout.
